// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state type, default sizes and length helpers for the sequence detector
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, READY, ARMED} state_t;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W = 8;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  localparam int LEN_W = len_w(DEF_MAX_LEN);
  function automatic logic len_ok(input int len, input int max_len);
    return len >= 1 && len <= max_len;
  endfunction
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: host/stream side bundle of the sequence detector controller
interface seq_det_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = seq_det_pkg::len_w(MAX_LEN);
  logic cfg_valid, cfg_ready, cfg_overlap, cfg_err;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic arm, disarm, cnt_clr, In, in_valid, out, armed;
  logic [CNT_W-1:0] match_cnt;
  modport master(
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, arm, disarm, cnt_clr, In, in_valid,
    input cfg_ready, cfg_err, out, match_cnt, armed
  );
  modport slave(
    input cfg_valid, cfg_pattern, cfg_len, cfg_overlap, arm, disarm, cnt_clr, In, in_valid,
    output cfg_ready, cfg_err, out, match_cnt, armed
  );
endinterface

// File: rtl/seq_match_core.sv
// seq_match_core: history shift register, seen counter and masked Mealy compare
module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               out
);
  logic [MAX_LEN-2:0] history;
  logic [MAX_LEN-1:0] window, mask;
  logic [LEN_W-1:0] seen;
  logic [LEN_W:0] seen_inc;
  always_comb begin
    window = {history, din};
    mask = ~({MAX_LEN{1'b1}} << len);
    seen_inc = {1'b0, seen} + (LEN_W+1)'(1);
    out = en && (seen_inc >= {1'b0, len}) && (((window ^ pattern) & mask) == '0);
  end
  // seen saturates at MAX_LEN; a non-overlapping match restarts it while history keeps shifting
  always_ff @(posedge clk)
    if (!rst || clr) begin
      history <= '0;
      seen <= '0;
    end else if (en) begin
      history <= window[MAX_LEN-2:0];
      seen <= (out && !overlap) ? '0
            : (seen_inc > (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seen_inc[LEN_W-1:0];
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: config handshake, arm/disarm FSM and saturating match counter around seq_match_core
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  seq_det_if.slave bus
);
  localparam int LEN_W = len_w(MAX_LEN);
  state_t state, nxt;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic overlap, err, accept, legal, load, en, clr, hit;
  always_comb begin
    accept = bus.cfg_valid && (state != ARMED);
    legal = len_ok(int'(bus.cfg_len), MAX_LEN);
    load = accept && legal;
    en = (state == ARMED) && bus.in_valid && !bus.disarm;
    nxt = load ? READY
        : (state == READY && bus.arm && !bus.disarm) ? ARMED
        : (state == ARMED && bus.disarm) ? READY : state;
    clr = load || (state != ARMED && nxt == ARMED);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      pattern <= '0;
      len <= '0;
      overlap <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      err <= accept && !legal;
      if (load) begin
        pattern <= bus.cfg_pattern;
        len <= bus.cfg_len;
        overlap <= bus.cfg_overlap;
      end
      if (bus.cnt_clr || load) cnt <= '0;
      else if (hit && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) core (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .din(bus.In),
    .pattern(pattern), .len(len), .overlap(overlap), .out(hit)
  );
  assign bus.cfg_ready = state != ARMED;
  assign bus.cfg_err = err;
  assign bus.out = hit;
  assign bus.match_cnt = cnt;
  assign bus.armed = state == ARMED;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed scenarios plus randomized streams checked against a queue-based model
module tb_seq_det_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  seq_det_if #(.MAX_LEN(8), .CNT_W(8)) b8();
  seq_det_if #(.MAX_LEN(8), .CNT_W(2)) b2();
  seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut8(.clk(clk), .rst(rst), .bus(b8));
  seq_det_ctrl #(.MAX_LEN(8), .CNT_W(2)) dut2(.clk(clk), .rst(rst), .bus(b2));
  int checks = 0;
  int failures = 0;
  logic o8, o2;
  typedef struct {
    logic [7:0] p; logic [3:0] l; logic v; logic [15:0] s; int n; logic [15:0] m; int c;
  } case_t;
  case_t cs[4] = '{
    '{8'b111, 4'd3, 1'b1, 16'b1_0111_1101, 9, 16'h070, 3},
    '{8'b111, 4'd3, 1'b0, 16'b1_0111_1101, 9, 16'h010, 1},
    '{8'b1011, 4'd4, 1'b1, 16'b110_1101, 7, 16'h048, 2},
    '{8'b1011, 4'd4, 1'b0, 16'b110_1101, 7, 16'h008, 1}
  };
  logic [7:0] m_pat;
  int m_len, m_seen, m_cnt;
  bit m_ovl, m_armed;
  bit m_hist[$];

  task automatic cyc();
    @(negedge clk);
    o8 = b8.out;
    o2 = b2.out;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg8(input logic [7:0] p, input logic [3:0] l, input logic v);
    b8.cfg_valid = 1'b1; b8.cfg_pattern = p; b8.cfg_len = l; b8.cfg_overlap = v;
    cyc();
    b8.cfg_valid = 1'b0;
  endtask
  task automatic arm8();
    b8.arm = 1'b1; cyc(); b8.arm = 1'b0;
  endtask
  task automatic disarm8();
    b8.disarm = 1'b1; cyc(); b8.disarm = 1'b0;
  endtask
  task automatic bit8(input logic b);
    b8.in_valid = 1'b1; b8.In = b; cyc(); b8.in_valid = 1'b0;
  endtask

  function automatic bit model_match(input bit b);
    if (m_seen + 1 < m_len) return 1'b0;
    if (m_pat[0] != b) return 1'b0;
    for (int k = 1; k < m_len; k++) if (m_pat[k] != m_hist[m_hist.size() - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    cyc(); cyc();
    checks++; if (b8.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", b8.cfg_ready); end
    checks++; if (b8.armed !== 1'b0) begin failures++; $display("FAIL reset_armed: got %b expected 0", b8.armed); end
    checks++; if (b8.match_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", b8.match_cnt); end
    checks++; if (b8.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", b8.cfg_err); end
    checks++; if (o8 !== 1'b0) begin failures++; $display("FAIL reset_out: got %b expected 0", o8); end
    checks++; if (b2.match_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt2: got %0d expected 0", b2.match_cnt); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_directed();
    for (int c = 0; c < 4; c++) begin
      disarm8();
      cfg8(cs[c].p, cs[c].l, cs[c].v);
      arm8();
      checks++; if (b8.armed !== 1'b1) begin failures++; $display("FAIL dir%0d_armed: got %b expected 1", c, b8.armed); end
      for (int i = 0; i < cs[c].n; i++) begin
        bit8(cs[c].s[i]);
        checks++; if (o8 !== cs[c].m[i]) begin failures++; $display("FAIL dir%0d_out bit%0d: got %b expected %b", c, i + 1, o8, cs[c].m[i]); end
      end
      checks++; if (b8.match_cnt !== 8'(cs[c].c)) begin failures++; $display("FAIL dir%0d_cnt: got %0d expected %0d", c, b8.match_cnt, cs[c].c); end
    end
    disarm8();
  endtask

  task automatic test_cfg_err();
    logic [2:0] s;
    rst = 1'b0; cyc(); rst = 1'b1;
    cfg8(8'h00, 4'd0, 1'b0);
    checks++; if (b8.cfg_err !== 1'b1) begin failures++; $display("FAIL err_len0: got %b expected 1", b8.cfg_err); end
    cyc();
    checks++; if (b8.cfg_err !== 1'b0) begin failures++; $display("FAIL err_pulse: got %b expected 0", b8.cfg_err); end
    arm8();
    checks++; if (b8.armed !== 1'b0) begin failures++; $display("FAIL err_idle_arm: got %b expected 0", b8.armed); end
    cfg8(8'hff, 4'd9, 1'b0);
    checks++; if (b8.cfg_err !== 1'b1) begin failures++; $display("FAIL err_len9_idle: got %b expected 1", b8.cfg_err); end
    arm8();
    checks++; if (b8.armed !== 1'b0) begin failures++; $display("FAIL err_idle_arm2: got %b expected 0", b8.armed); end
    cfg8(8'b101, 4'd3, 1'b1);
    checks++; if (b8.cfg_err !== 1'b0) begin failures++; $display("FAIL err_legal: got %b expected 0", b8.cfg_err); end
    s = 3'b101;
    for (int r = 0; r < 2; r++) begin
      arm8();
      for (int i = 0; i < 3; i++) begin
        bit8(s[i]);
        checks++; if (o8 !== (i == 2)) begin failures++; $display("FAIL err_run%0d_out bit%0d: got %b expected %b", r, i + 1, o8, i == 2); end
      end
      checks++; if (b8.match_cnt !== 8'(r + 1)) begin failures++; $display("FAIL err_run%0d_cnt: got %0d expected %0d", r, b8.match_cnt, r + 1); end
      disarm8();
      if (r == 0) begin
        cfg8(8'hff, 4'd9, 1'b0);
        checks++; if (b8.cfg_err !== 1'b1) begin failures++; $display("FAIL err_len9_ready: got %b expected 1", b8.cfg_err); end
        checks++; if (b8.match_cnt !== 8'd1) begin failures++; $display("FAIL err_cnt_kept: got %0d expected 1", b8.match_cnt); end
      end
    end
  endtask

  task automatic test_saturate();
    b2.cfg_valid = 1'b1; b2.cfg_pattern = 8'h01; b2.cfg_len = 4'd1; b2.cfg_overlap = 1'b1;
    cyc();
    b2.cfg_valid = 1'b0; b2.arm = 1'b1;
    cyc();
    b2.arm = 1'b0; b2.in_valid = 1'b1; b2.In = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++; if (o2 !== 1'b1) begin failures++; $display("FAIL sat_out%0d: got %b expected 1", i, o2); end
      checks++; if (b2.match_cnt !== 2'(i > 3 ? 3 : i)) begin failures++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, b2.match_cnt, i > 3 ? 3 : i); end
    end
    b2.cnt_clr = 1'b1;
    cyc();
    checks++; if (o2 !== 1'b1) begin failures++; $display("FAIL sat_clr_out: got %b expected 1", o2); end
    checks++; if (b2.match_cnt !== 2'd0) begin failures++; $display("FAIL sat_clr_cnt: got %0d expected 0", b2.match_cnt); end
    b2.cnt_clr = 1'b0; b2.in_valid = 1'b0;
  endtask

  task automatic test_arm_disarm();
    cfg8(8'h01, 4'd1, 1'b1);
    b8.arm = 1'b1; b8.disarm = 1'b1;
    cyc();
    b8.arm = 1'b0; b8.disarm = 1'b0;
    checks++; if (b8.armed !== 1'b0) begin failures++; $display("FAIL ad_both_armed: got %b expected 0", b8.armed); end
    checks++; if (b8.cfg_ready !== 1'b1) begin failures++; $display("FAIL ad_both_ready: got %b expected 1", b8.cfg_ready); end
    arm8();
    checks++; if (b8.cfg_ready !== 1'b0) begin failures++; $display("FAIL ad_armed_ready: got %b expected 0", b8.cfg_ready); end
    b8.disarm = 1'b1; b8.in_valid = 1'b1; b8.In = 1'b1;
    cyc();
    b8.disarm = 1'b0; b8.in_valid = 1'b0;
    checks++; if (o8 !== 1'b0) begin failures++; $display("FAIL ad_disarm_out: got %b expected 0", o8); end
    checks++; if (b8.armed !== 1'b0 || b8.match_cnt !== 8'd0) begin failures++; $display("FAIL ad_disarm_state: got armed=%b cnt=%0d expected armed=0 cnt=0", b8.armed, b8.match_cnt); end
    arm8();
    bit8(1'b1);
    checks++; if (o8 !== 1'b1 || b8.match_cnt !== 8'd1) begin failures++; $display("FAIL ad_match: got out=%b cnt=%0d expected out=1 cnt=1", o8, b8.match_cnt); end
    rst = 1'b0; b8.in_valid = 1'b1; b8.In = 1'b1;
    cyc();
    rst = 1'b1;
    checks++; if (b8.armed !== 1'b0 || b8.match_cnt !== 8'd0 || b8.cfg_ready !== 1'b1) begin failures++; $display("FAIL ad_rst: got armed=%b cnt=%0d ready=%b expected 0 0 1", b8.armed, b8.match_cnt, b8.cfg_ready); end
    cyc();
    b8.in_valid = 1'b0;
    checks++; if (o8 !== 1'b0) begin failures++; $display("FAIL ad_rst_out: got %b expected 0", o8); end
    arm8();
    checks++; if (b8.armed !== 1'b0) begin failures++; $display("FAIL ad_rst_cfg_lost: got %b expected 0", b8.armed); end
  endtask

  task automatic test_random();
    logic a, d, iv, c, bb, em;
    logic [7:0] p;
    int l, pos;
    for (int r = 0; r < 12; r++) begin
      disarm8();
      p = 8'($urandom);
      l = ($urandom % 2 == 1) ? $urandom_range(1, 3) : $urandom_range(1, 8);
      cfg8(p, 4'(l), 1'($urandom));
      m_pat = p; m_len = l; m_ovl = b8.cfg_overlap; m_cnt = 0; m_armed = 1'b0;
      pos = l - 1;
      for (int k = 0; k < 80; k++) begin
        a = ($urandom % 4) == 0; d = ($urandom % 30) == 0;
        iv = ($urandom % 4) != 0; c = ($urandom % 20) == 0;
        bb = ($urandom % 3 == 0) ? 1'($urandom) : p[pos];
        if (iv) pos = (pos == 0) ? l - 1 : pos - 1;
        b8.arm = a; b8.disarm = d; b8.in_valid = iv; b8.cnt_clr = c; b8.In = bb;
        em = 1'b0;
        if (m_armed && d) m_armed = 1'b0;
        else if (m_armed && iv) begin
          em = model_match(bb);
          m_hist.push_back(bb);
          if (m_hist.size() > 16) void'(m_hist.pop_front());
          m_seen = (em && !m_ovl) ? 0 : m_seen + 1;
        end else if (!m_armed && a && !d) begin
          m_armed = 1'b1; m_hist.delete(); m_seen = 0;
        end
        m_cnt = c ? 0 : (em && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        cyc();
        checks++; if (o8 !== em) begin failures++; $display("FAIL rnd%0d_%0d_out: got %b expected %b", r, k, o8, em); end
        checks++; if (b8.match_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL rnd%0d_%0d_cnt: got %0d expected %0d", r, k, b8.match_cnt, m_cnt); end
        checks++; if (b8.armed !== m_armed) begin failures++; $display("FAIL rnd%0d_%0d_armed: got %b expected %b", r, k, b8.armed, m_armed); end
      end
      b8.arm = 1'b0; b8.disarm = 1'b0; b8.in_valid = 1'b0; b8.cnt_clr = 1'b0;
    end
  endtask

  initial begin
    b8.cfg_valid = 0; b8.cfg_pattern = 0; b8.cfg_len = 0; b8.cfg_overlap = 0;
    b8.arm = 0; b8.disarm = 0; b8.cnt_clr = 0; b8.In = 0; b8.in_valid = 0;
    b2.cfg_valid = 0; b2.cfg_pattern = 0; b2.cfg_len = 0; b2.cfg_overlap = 0;
    b2.arm = 0; b2.disarm = 0; b2.cnt_clr = 0; b2.In = 0; b2.in_valid = 0;
    test_reset();
    test_directed();
    test_cfg_err();
    test_saturate();
    test_arm_disarm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
